// File: rtl/dual_port_mem_responder.sv
// Unified 2^ADDR_W x DATA_W memory serving a single-cycle CPU's fetch (A) and data (B) ports.
// With MEM_BOOT_LOAD_EN defined, a boot loader fills the array from a byte stream and holds the CPU until done.
module dual_port_mem_responder #(
  parameter int    ADDR_W    = 8,
  parameter int    DATA_W    = 8,
  parameter int    LOAD_LEN  = 256,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] mem_addr_a,
  output logic [DATA_W-1:0] Instr_out,
  input  logic              mem_write_enable,
  input  logic [ADDR_W-1:0] mem_addr_b,
  input  logic [DATA_W-1:0] mem_write_data_b,
  output logic [DATA_W-1:0] mem_data_out_b,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  output logic              cpu_hold
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [0:DEPTH-1];
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  // Array is deliberately not reset; contents survive reset and a reload overwrites them.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

`ifdef MEM_BOOT_LOAD_EN

  typedef enum logic {LOAD, RUN} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(LOAD_LEN - 1);

  state_t          state_q, state_d;
  logic [ADDR_W:0] load_ptr_q, load_ptr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= LOAD;
      load_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      load_ptr_q <= load_ptr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    load_ptr_d     = load_ptr_q;
    wr_en          = 1'b0;
    wr_addr        = mem_addr_b;
    wr_data        = mem_write_data_b;
    load_ready     = 1'b0;
    load_done      = 1'b0;
    cpu_hold       = 1'b1;
    Instr_out      = '0;
    mem_data_out_b = '0;
    case (state_q)
      LOAD: begin
        // rst gating keeps outputs at reset values and blocks array writes while reset is held.
        load_ready = rst;
        if (rst && load_valid) begin
          wr_en      = 1'b1;
          wr_addr    = load_ptr_q[ADDR_W-1:0];
          wr_data    = load_data;
          load_ptr_d = load_ptr_q + 1'b1;
          if (load_ptr_q == LAST_IDX) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        load_done      = 1'b1;
        cpu_hold       = 1'b0;
        Instr_out      = mem_q[mem_addr_a];
        mem_data_out_b = mem_q[mem_addr_b];
        wr_en          = mem_write_enable;
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

`else

  logic unused_loader;
  assign unused_loader = ^{load_valid, load_data, (LOAD_LEN == 0)};

  always_comb begin
    wr_en          = mem_write_enable && rst;
    wr_addr        = mem_addr_b;
    wr_data        = mem_write_data_b;
    load_ready     = 1'b0;
    load_done      = 1'b1;
    cpu_hold       = 1'b0;
    Instr_out      = mem_q[mem_addr_a];
    mem_data_out_b = mem_q[mem_addr_b];
  end

`endif

endmodule

// File: tb/tb_dual_port_mem_responder.sv
// Directed self-checking bench for dual_port_mem_responder; covers both MEM_BOOT_LOAD_EN builds.
module tb_dual_port_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] mem_addr_a;
  logic [7:0] Instr_out;
  logic       mem_write_enable;
  logic [7:0] mem_addr_b;
  logic [7:0] mem_write_data_b;
  logic [7:0] mem_data_out_b;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       load_done;
  logic       cpu_hold;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  dual_port_mem_responder #(
    .ADDR_W   (8),
    .DATA_W   (8),
    .LOAD_LEN (4),
    .INIT_FILE("")
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_addr_a      (mem_addr_a),
    .Instr_out       (Instr_out),
    .mem_write_enable(mem_write_enable),
    .mem_addr_b      (mem_addr_b),
    .mem_write_data_b(mem_write_data_b),
    .mem_data_out_b  (mem_data_out_b),
    .load_valid      (load_valid),
    .load_data       (load_data),
    .load_ready      (load_ready),
    .load_done       (load_done),
    .cpu_hold        (cpu_hold)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bwrite(input logic [7:0] a, input logic [7:0] d);
    mem_write_enable = 1'b1;
    mem_addr_b       = a;
    mem_write_data_b = d;
    tick();
    mem_write_enable = 1'b0;
  endtask

  initial begin
    logic [7:0] boot_bytes [4];
    boot_bytes[0] = 8'h11; boot_bytes[1] = 8'h22; boot_bytes[2] = 8'h33; boot_bytes[3] = 8'h44;

    rst              = 1'b0;
    mem_addr_a       = '0;
    mem_addr_b       = '0;
    mem_write_enable = 1'b0;
    mem_write_data_b = '0;
    load_valid       = 1'b0;
    load_data        = '0;
    #12;

`ifdef MEM_BOOT_LOAD_EN
    check("rst_ready", load_ready, 0);
    check("rst_done", load_done, 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_instr", Instr_out, 8'h00);
    check("rst_dob", mem_data_out_b, 8'h00);

    tick();
    rst = 1'b1;
    #1;
    check("load_ready", load_ready, 1);

    // stalled loader: only valid cycles advance the pointer
    load_valid = 1'b1; load_data = 8'hA0; tick();
    load_valid = 1'b0; tick();
    load_valid = 1'b1; load_data = 8'hA1; tick();
    load_valid = 1'b0; tick();
    check("stall_hold", cpu_hold, 1);
    check("stall_ready", load_ready, 1);
    check("stall_done", load_done, 0);
    load_valid = 1'b1; load_data = 8'hA2; tick();
    load_data = 8'hA3; tick();
    load_valid = 1'b0;
    #1;
    check("stall_done_end", load_done, 1);
    mem_addr_a = 8'd0; #1; check("stall_m0", Instr_out, 8'hA0);
    mem_addr_a = 8'd1; #1; check("stall_m1", Instr_out, 8'hA1);

    rst = 1'b0;
    #1;
    check("rerst_instr", Instr_out, 8'h00);
    tick();
    rst = 1'b1;

    // boot load with a port-B write attempt that must be ignored
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = boot_bytes[i];
      mem_write_enable = (i == 2);
      mem_addr_b       = 8'd1;
      mem_write_data_b = 8'hFF;
      #1;
      check("boot_hold_pre", cpu_hold, 1);
      tick();
    end
    mem_write_enable = 1'b0;
    load_valid = 1'b0;
    #1;
    check("boot_hold_post", cpu_hold, 0);
    check("boot_done_post", load_done, 1);
    check("boot_ready_post", load_ready, 0);
    for (int i = 0; i < 4; i++) begin
      mem_addr_a = 8'(i);
      #1;
      check("boot_instr", Instr_out, boot_bytes[i]);
    end
    mem_addr_b = 8'd1;
    #1;
    check("load_wr_ignored", mem_data_out_b, 8'h22);

    // load_valid ignored in RUN
    load_valid = 1'b1; load_data = 8'hEE; tick(); tick();
    load_valid = 1'b0;
    mem_addr_a = 8'd0; #1;
    check("run_valid_ignored", Instr_out, 8'h11);
`else
    check("rst_ready", load_ready, 0);
    check("rst_done", load_done, 1);
    check("rst_hold", cpu_hold, 0);
    tick();
    rst = 1'b1;
    bwrite(8'h00, 8'h7E);
    bwrite(8'hFF, 8'hC3);
    mem_addr_a = 8'h00; #1; check("nl_m00", Instr_out, 8'h7E);
    mem_addr_a = 8'hFF; #1; check("nl_mff", Instr_out, 8'hC3);
    mem_addr_b = 8'hFF; #1; check("nl_dob_ff", mem_data_out_b, 8'hC3);

    load_valid = 1'b1; load_data = 8'h99; tick(); tick();
    load_valid = 1'b0;
    mem_addr_a = 8'h00; #1;
    check("nl_valid_ignored", Instr_out, 8'h7E);
    check("nl_ready", load_ready, 0);
    check("nl_done", load_done, 1);

    mem_addr_b = 8'h10; mem_write_data_b = 8'h3C; tick();
    bwrite(8'h10, 8'h5A);
    mem_write_data_b = 8'h77; tick();
    #1;
    check("nl_we_low", mem_data_out_b, 8'h5A);
`endif

    // port B write: old data same cycle, new data after the edge on both ports
    bwrite(8'h80, 8'hA5);
    mem_write_enable = 1'b1;
    mem_addr_b       = 8'h80;
    mem_write_data_b = 8'h5C;
    mem_addr_a       = 8'h80;
    #1;
    check("wr_old_b", mem_data_out_b, 8'hA5);
    check("wr_old_a", Instr_out, 8'hA5);
    tick();
    mem_write_enable = 1'b0;
    #1;
    check("wr_new_b", mem_data_out_b, 8'h5C);
    check("wr_new_a", Instr_out, 8'h5C);

`ifdef MEM_BOOT_LOAD_EN
    // reset mid-load
    rst = 1'b0;
    tick();
    rst = 1'b1;
    load_valid = 1'b1; load_data = 8'hB0; tick();
    load_data = 8'hB1; tick();
    load_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("mid_hold", cpu_hold, 1);
    check("mid_ready", load_ready, 0);
    check("mid_done", load_done, 0);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      load_valid = 1'b1;
      load_data  = 8'hC0 + 8'(i);
      tick();
    end
    load_valid = 1'b0;
    #1;
    check("mid_done_end", load_done, 1);
    mem_addr_a = 8'd0; #1; check("mid_m0", Instr_out, 8'hC0);
    mem_addr_a = 8'd1; #1; check("mid_m1", Instr_out, 8'hC1);
    mem_addr_a = 8'd3; #1; check("mid_m3", Instr_out, 8'hC3);
`else
    // array survives reset and stays visible while reset is held
    rst = 1'b0;
    mem_addr_a = 8'h00;
    mem_addr_b = 8'hFF;
    #1;
    check("rst_keep_a", Instr_out, 8'h7E);
    check("rst_keep_b", mem_data_out_b, 8'hC3);
    tick();
    rst = 1'b1;
    #1;
    check("post_rst_hold", cpu_hold, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
